core_mem_responder: RTL

Memory-side responder for the core instruction/data memory interface, used in the core testbench. It grants and completes instruction-fetch and data read/write requests against one shared word array. Response latency, outstanding-request depth and periodic grant stalls are configurable so core fetch and LSU handshake behaviour can be exercised.

---
 rtl/core_mem_responder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/core_mem_responder.sv
// core_mem_responder
//   Memory-side responder for the core instruction/data memory interface.
//   One shared word array serves an instruction-fetch port and a data
//   read/write port. Each port has its own response pipeline, outstanding
//   counter and periodic grant-stall counter.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   instr_req_i / instr_gnt_o    fetch request / combinational grant
//   instr_addr_i                 fetch byte address
//   instr_rvalid_o, instr_rdata_o  fetch response (rdata 0 when not valid)
//   data_req_i / data_gnt_o      data request / combinational grant
//   data_addr_i, data_we_i, data_be_i, data_wdata_i  data access attributes
//   data_rvalid_o, data_rdata_o  data response (rdata 0 for writes and idle)
//   err_o                        sticky out-of-range access flag
//
// Handshake: a request transfers in any cycle where req and gnt are both
// high; the attributes are sampled in that cycle. The requester holds req
// and its attributes stable until it sees gnt. rvalid is a one-cycle
// strobe with no back-pressure; responses return in grant order per port.
module core_mem_responder #(
   parameter int INSTR_DATA_WIDTH = 32,
   parameter int INSTR_ADDR_WIDTH = 32,
   parameter int DATA_WIDTH       = 32,
   parameter int ADDR_WIDTH       = 32,
   parameter int MEM_WORDS        = 16384,
   parameter int LATENCY          = 1,
   parameter int MAX_OUTSTANDING  = 2,
   parameter int GNT_STALL_PERIOD = 0
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        instr_req_i,
   output logic                        instr_gnt_o,
   output logic                        instr_rvalid_o,
   input  logic [INSTR_ADDR_WIDTH-1:0] instr_addr_i,
   output logic [INSTR_DATA_WIDTH-1:0] instr_rdata_o,
   input  logic                        data_req_i,
   output logic                        data_gnt_o,
   output logic                        data_rvalid_o,
   input  logic [ADDR_WIDTH-1:0]       data_addr_i,
   input  logic                        data_we_i,
   input  logic [3:0]                  data_be_i,
   input  logic [DATA_WIDTH-1:0]       data_wdata_i,
   output logic [DATA_WIDTH-1:0]       data_rdata_o,
   output logic                        err_o
);

   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam int CW    = $clog2(MAX_OUTSTANDING + 1);
   localparam int SW    = (GNT_STALL_PERIOD > 1) ? $clog2(GNT_STALL_PERIOD) : 1;
   localparam logic [CW-1:0]         MAX_C      = CW'(MAX_OUTSTANDING);
   localparam logic [SW-1:0]         STALL_LAST = SW'(GNT_STALL_PERIOD - 1);
   localparam logic [DATA_WIDTH-1:0] OOR_DATA   = DATA_WIDTH'(32'hDEADBEEF);

   // Not reset: contents survive reset and are preloaded by the bench.
   logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

   logic [CW-1:0] instr_out_q, data_out_q;
   logic [SW-1:0] instr_stall_q, data_stall_q;
   logic          instr_stall, data_stall;
   logic          instr_hs, data_hs;
   logic          instr_oor, data_oor;
   logic [IDX_W-1:0] instr_idx, data_idx;
   logic [INSTR_DATA_WIDTH-1:0] instr_rd;
   logic [DATA_WIDTH-1:0]       data_rd;
   logic [LATENCY-1:0]          instr_v_q, data_v_q;
   logic [INSTR_DATA_WIDTH-1:0] instr_d_q [LATENCY];
   logic [DATA_WIDTH-1:0]       data_d_q  [LATENCY];
   logic                        err_q;

   // Any set bit above the word index range marks the access out of range.
   assign instr_idx = instr_addr_i[IDX_W+1:2];
   assign data_idx  = data_addr_i[IDX_W+1:2];
   assign instr_oor = (instr_addr_i >> (IDX_W + 2)) != '0;
   assign data_oor  = (data_addr_i  >> (IDX_W + 2)) != '0;

   assign instr_stall = (GNT_STALL_PERIOD >= 2) && (instr_stall_q == STALL_LAST);
   assign data_stall  = (GNT_STALL_PERIOD >= 2) && (data_stall_q  == STALL_LAST);

   // The limit uses the registered count only; a same-cycle retire does
   // not free a slot until the next cycle.
   assign instr_gnt_o = instr_req_i && !rst_i && (instr_out_q < MAX_C) && !instr_stall;
   assign data_gnt_o  = data_req_i  && !rst_i && (data_out_q  < MAX_C) && !data_stall;
   assign instr_hs    = instr_req_i && instr_gnt_o;
   assign data_hs     = data_req_i  && data_gnt_o;

   // Array read happens in the handshake cycle, before the write of the
   // same edge commits, so a colliding fetch sees the old word.
   assign instr_rd = instr_oor ? OOR_DATA : mem_q[instr_idx];
   assign data_rd  = data_we_i ? '0 : (data_oor ? OOR_DATA : mem_q[data_idx]);

   assign instr_rvalid_o = instr_v_q[LATENCY-1];
   assign instr_rdata_o  = instr_d_q[LATENCY-1];
   assign data_rvalid_o  = data_v_q[LATENCY-1];
   assign data_rdata_o   = data_d_q[LATENCY-1];
   assign err_o          = err_q;

   always_ff @(posedge clk_i) begin
      if (data_hs && data_we_i && !data_oor) begin
         for (int i = 0; i < 4; i++) begin
            if (data_be_i[i]) mem_q[data_idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         instr_v_q     <= '0;
         data_v_q      <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            instr_d_q[i] <= '0;
            data_d_q[i]  <= '0;
         end
         instr_out_q   <= '0;
         data_out_q    <= '0;
         instr_stall_q <= '0;
         data_stall_q  <= '0;
         err_q         <= 1'b0;
      end else begin
         // Idle stages carry zero data so rdata is 0 whenever rvalid is low.
         instr_v_q[0] <= instr_hs;
         data_v_q[0]  <= data_hs;
         instr_d_q[0] <= instr_hs ? instr_rd : '0;
         data_d_q[0]  <= data_hs  ? data_rd  : '0;
         for (int i = 1; i < LATENCY; i++) begin
            instr_v_q[i] <= instr_v_q[i-1];
            data_v_q[i]  <= data_v_q[i-1];
            instr_d_q[i] <= instr_d_q[i-1];
            data_d_q[i]  <= data_d_q[i-1];
         end

         if (instr_hs && !instr_rvalid_o)      instr_out_q <= instr_out_q + CW'(1);
         else if (!instr_hs && instr_rvalid_o) instr_out_q <= instr_out_q - CW'(1);
         if (data_hs && !data_rvalid_o)        data_out_q  <= data_out_q + CW'(1);
         else if (!data_hs && data_rvalid_o)   data_out_q  <= data_out_q - CW'(1);

         // Free-running regardless of requests.
         if (GNT_STALL_PERIOD < 2 || instr_stall_q == STALL_LAST) instr_stall_q <= '0;
         else                                                     instr_stall_q <= instr_stall_q + SW'(1);
         if (GNT_STALL_PERIOD < 2 || data_stall_q == STALL_LAST)  data_stall_q  <= '0;
         else                                                     data_stall_q  <= data_stall_q + SW'(1);

         if ((instr_hs && instr_oor) || (data_hs && data_oor)) err_q <= 1'b1;
      end
   end

endmodule
